shr_serializer: RTL and testbench
=================================

# shr_serializer

Controller that sequences a W-bit load/shift-right register to serialize parallel words LSB-first onto a one-bit stream. It accepts a word through a start/ready handshake and loads it into the register. It then issues one right-shift per accepted output bit, with backpressure from the downstream consumer. On completion it pulses `done`. It sits between a parallel producer and any bit-serial consumer.

## Interface
- `W`, default 8: word width in bits; legal range W ≥ 2.
- `clk` in 1: single clock; all logic updates on rising edge.
- `rst` in 1: reset, synchronous, active-high; has priority over every other input.
- `start` in 1: request to serialize `data_in`; sampled only while `ready`=1.
- `data_in` in W: word to transmit; captured on the accepting edge.
- `s_ready` in 1: consumer can take the current bit this cycle.
- `ready` out 1: controller idle, able to accept `start`.
- `s_out` out 1: current serial bit (register bit 0).
- `s_valid` out 1: `s_out` is valid this cycle.
- `done` out 1: one-cycle pulse after the last bit has been transferred.

## Operation
- FSM states: IDLE, SHIFT, DONE. Encoding is defined in the package.
- Reset (rst=1 at an edge):
  - state becomes IDLE, bit counter 0, shift register 0.
  - Outputs after the edge: `ready`=1, `s_valid`=0, `s_out`=0, `done`=0.
  - Applies mid-transfer: the word is abandoned and no `done` is issued.
- IDLE:
  - `ready`=1.
  - If `start`=1: assert `ld` to the register (loads `data_in`), clear counter, go to SHIFT.
  - If `start`=0: stay in IDLE, register holds.
- SHIFT:
  - `ready`=0, `s_valid`=1, `s_out`=reg[0].
  - A bit transfers in a cycle when `s_valid`=1 and `s_ready`=1. On that edge: `sh`=1 (zero fill from MSB) and counter += 1.
  - `s_ready`=0: `sh`=0; counter, register and `s_out` hold.
  - When a transfer occurs with counter = W-1: go to DONE.
- DONE:
  - `done`=1, `ready`=0, `s_valid`=0.
  - Unconditionally go to IDLE next edge.
- `start` outside IDLE is ignored; it is not queued.
- Counter width is $clog2(W+1). It never exceeds W-1 in SHIFT.
- Register priority is sh > ld. The controller never asserts both in the same cycle.

## Timing
- Accepting edge e0 (IDLE, start=1) → bit0 is visible on `s_out` with `s_valid`=1 in the cycle after e0.
- With `s_ready` held at 1:
  - bits 0..W-1 occupy W consecutive cycles.
  - `done` is high in cycle W+1 after e0.
  - `ready`=1 again in cycle W+2.
  - Minimum period is W+2 cycles per word.
- Each `s_ready`=0 cycle during SHIFT adds exactly one cycle to the transfer; no bit is duplicated or lost.
- `done` is high for exactly one cycle per completed word. No back-to-back words: `start` together with `done` is ignored.
- `rst` and `start` at the same edge: reset wins, state is IDLE.
- `rst`=1 for multiple cycles: outputs stay at their reset values throughout.

## Structure
- Package `shr_pkg`:
  - FSM state typedef (IDLE, SHIFT, DONE).
  - Default width constant `SHR_W`=8.
- Sub-module `shr_reg`, parameterized W:
  - Ports: `clk`, `rst`, `ld`, `sh`, `data_in`, `data_out`.
  - Synchronous active-high reset to 0, sh > ld priority, logical right shift.
- Top holds the FSM and counter. All outputs are combinational decodes of state and `shr_reg.data_out`[0]. No other logic.

## Test plan
- Reset: hold rst=1 for 2 cycles with start=1 → `ready`=1, `s_valid`=0, `s_out`=0, `done`=0 throughout and after.
- Basic, W=8, `s_ready`=1: start with `data_in`=8'b10101010 → `s_out` = 0,1,0,1,0,1,0,1 over cycles 1–8 with `s_valid`=1; `done`=1 at cycle 9; `ready`=1 at cycle 10.
- Backpressure, `data_in`=8'hC3: drop `s_ready` for 3 cycles after bit 2 → bit 2 (0) held 4 cycles; full sequence 1,1,0,0,0,0,1,1; `done` at cycle 12.
- Start while busy: pulse start with 8'hFF during SHIFT of 8'h01 → output 1,0,0,0,0,0,0,0 only; exactly one `done`.
- Reset mid-transfer: assert rst after bit 3 of 8'hA5 → next cycle IDLE, `ready`=1, no `done`. A new start with 8'h0F then yields 1,1,1,1,0,0,0,0.
- Width check, W=5: start with 5'b10011 → 1,1,0,0,1; `done` at cycle 6.

Source files
------------

// File: rtl/shr_pkg.sv
// Shared types and defaults for the shift-register serializer.
package shr_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int unsigned SHR_W = 8;

endpackage

// File: rtl/shr_reg.sv
// W-bit load / logical-shift-right register; shift takes priority over load.
module shr_reg
  import shr_pkg::*;
#(
  parameter int unsigned W = SHR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ld,
  input  logic         sh,
  input  logic [W-1:0] data_in,
  output logic [W-1:0] data_out
);

  logic [W-1:0] data_q, data_d;

  always_comb begin
    data_d = data_q;
    if (sh) begin
      data_d = {1'b0, data_q[W-1:1]};
    end else if (ld) begin
      data_d = data_in;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      data_q <= '0;
    end else begin
      data_q <= data_d;
    end
  end

  assign data_out = data_q;

endmodule

// File: rtl/shr_serializer.sv
// Serializes W-bit words LSB-first with a start/ready input handshake and
// valid/ready backpressure on the bit stream; pulses done after the last bit.
module shr_serializer
  import shr_pkg::*;
#(
  parameter int unsigned W = SHR_W
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [W-1:0] data_in,
  input  logic         s_ready,
  output logic         ready,
  output logic         s_out,
  output logic         s_valid,
  output logic         done
);

  localparam int unsigned CW = $clog2(W + 1);

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          ld, sh;
  logic [W-1:0]  reg_data;

  shr_reg #(.W(W)) u_reg (
    .clk      (clk),
    .rst      (rst),
    .ld       (ld),
    .sh       (sh),
    .data_in  (data_in),
    .data_out (reg_data)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ld      = 1'b0;
    sh      = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          ld      = 1'b1;
          cnt_d   = '0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        if (s_ready) begin
          sh    = 1'b1;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == CW'(W - 1)) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  assign ready   = (state_q == IDLE);
  assign s_valid = (state_q == SHIFT);
  assign s_out   = s_valid & reg_data[0];
  assign done    = (state_q == DONE);

  a_ld_sh_exclusive: assert property (@(posedge clk) disable iff (rst) !(ld && sh));
  a_cnt_range: assert property (@(posedge clk) disable iff (rst)
    (state_q == SHIFT) |-> (cnt_q <= CW'(W - 1)));
  // Zero fill means a fully shifted word leaves the register empty.
  a_reg_drained: assert property (@(posedge clk) disable iff (rst)
    (state_q == DONE) |-> (reg_data == '0));

endmodule

// File: tb/tb_shr_serializer.sv
// Directed bench for shr_serializer at W=8 and W=5.
module tb_shr_serializer;

  logic       clk;
  logic       rst;
  logic       start8, s_ready8, ready8, s_out8, s_valid8, done8;
  logic [7:0] data8;
  logic       start5, s_ready5, ready5, s_out5, s_valid5, done5;
  logic [4:0] data5;

  int n_checks = 0;
  int n_fail   = 0;

  shr_serializer #(.W(8)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .data_in(data8), .s_ready(s_ready8),
    .ready(ready8), .s_out(s_out8), .s_valid(s_valid8), .done(done8)
  );

  shr_serializer #(.W(5)) dut5 (
    .clk(clk), .rst(rst), .start(start5), .data_in(data5), .s_ready(s_ready5),
    .ready(ready5), .s_out(s_out5), .s_valid(s_valid5), .done(done5)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; start8 = 1'b1; data8 = 8'hFF; start5 = 1'b1; data5 = 5'h1F;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_checks++;
      if ({ready8, s_valid8, s_out8, done8} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_hold8 cyc=%0d got=%b exp=1000", c, {ready8, s_valid8, s_out8, done8});
      end
      n_checks++;
      if ({ready5, s_valid5, s_out5, done5} !== 4'b1000) begin
        n_fail++;
        $display("FAIL reset_hold5 cyc=%0d got=%b exp=1000", c, {ready5, s_valid5, s_out5, done5});
      end
    end
    rst = 1'b0; start8 = 1'b0; start5 = 1'b0;
    tick();
    n_checks++;
    if ({ready8, s_valid8, s_out8, done8} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_after got=%b exp=1000", {ready8, s_valid8, s_out8, done8});
    end
  endtask

  task automatic test_basic();
    bit exp_seq[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
    s_ready8 = 1'b1; data8 = 8'b10101010; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({s_valid8, s_out8, ready8, done8} !== {1'b1, exp_seq[k], 2'b00}) begin
        n_fail++;
        $display("FAIL basic_bit%0d got v/o/r/d=%b exp=%b", k,
                 {s_valid8, s_out8, ready8, done8}, {1'b1, exp_seq[k], 2'b00});
      end
      tick();
    end
    n_checks++;
    if ({ready8, s_valid8, done8} !== 3'b001) begin
      n_fail++;
      $display("FAIL basic_done got r/v/d=%b exp=001", {ready8, s_valid8, done8});
    end
    tick();
    n_checks++;
    if ({ready8, s_valid8, done8} !== 3'b100) begin
      n_fail++;
      $display("FAIL basic_ready got r/v/d=%b exp=100", {ready8, s_valid8, done8});
    end
  endtask

  task automatic test_backpressure();
    bit exp_seq[11] = '{1, 1, 0, 0, 0, 0, 0, 0, 0, 1, 1};
    data8 = 8'hC3; s_ready8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int c = 1; c <= 11; c++) begin
      s_ready8 = (c >= 3 && c <= 5) ? 1'b0 : 1'b1;
      n_checks++;
      if ({s_valid8, s_out8, done8} !== {1'b1, exp_seq[c-1], 1'b0}) begin
        n_fail++;
        $display("FAIL bp_cycle%0d got v/o/d=%b exp=%b", c,
                 {s_valid8, s_out8, done8}, {1'b1, exp_seq[c-1], 1'b0});
      end
      tick();
    end
    s_ready8 = 1'b1;
    n_checks++;
    if ({done8, s_valid8} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_done12 got d/v=%b exp=10", {done8, s_valid8});
    end
    tick();
    n_checks++;
    if ({ready8, done8} !== 2'b10) begin
      n_fail++;
      $display("FAIL bp_ready13 got r/d=%b exp=10", {ready8, done8});
    end
  endtask

  task automatic test_start_while_busy();
    bit exp_seq[8] = '{1, 0, 0, 0, 0, 0, 0, 0};
    int dones = 0;
    data8 = 8'h01; s_ready8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) begin
        start8 = 1'b1; data8 = 8'hFF;
      end else begin
        start8 = 1'b0;
      end
      if (done8) dones++;
      n_checks++;
      if ({s_valid8, s_out8} !== {1'b1, exp_seq[k]}) begin
        n_fail++;
        $display("FAIL busy_bit%0d got v/o=%b exp=%b", k, {s_valid8, s_out8}, {1'b1, exp_seq[k]});
      end
      tick();
    end
    // start coinciding with done must not launch a second word
    start8 = 1'b1;
    if (done8) dones++;
    tick();
    start8 = 1'b0;
    for (int c = 0; c < 3; c++) begin
      if (done8) dones++;
      n_checks++;
      if ({ready8, s_valid8} !== 2'b10) begin
        n_fail++;
        $display("FAIL busy_idle%0d got r/v=%b exp=10", c, {ready8, s_valid8});
      end
      tick();
    end
    n_checks++;
    if (dones !== 1) begin
      n_fail++;
      $display("FAIL busy_done_count got=%0d exp=1", dones);
    end
  endtask

  task automatic test_reset_mid_transfer();
    bit exp_a5[4] = '{1, 0, 1, 0};
    bit exp_0f[8] = '{1, 1, 1, 1, 0, 0, 0, 0};
    data8 = 8'hA5; s_ready8 = 1'b1; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_checks++;
      if ({s_valid8, s_out8} !== {1'b1, exp_a5[k]}) begin
        n_fail++;
        $display("FAIL rmid_bit%0d got v/o=%b exp=%b", k, {s_valid8, s_out8}, {1'b1, exp_a5[k]});
      end
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3; c++) begin
      n_checks++;
      if ({ready8, s_valid8, s_out8, done8} !== 4'b1000) begin
        n_fail++;
        $display("FAIL rmid_idle%0d got=%b exp=1000", c, {ready8, s_valid8, s_out8, done8});
      end
      tick();
    end
    data8 = 8'h0F; start8 = 1'b1;
    tick();
    start8 = 1'b0;
    for (int k = 0; k < 8; k++) begin
      n_checks++;
      if ({s_valid8, s_out8, done8} !== {1'b1, exp_0f[k], 1'b0}) begin
        n_fail++;
        $display("FAIL rmid_new_bit%0d got v/o/d=%b exp=%b", k,
                 {s_valid8, s_out8, done8}, {1'b1, exp_0f[k], 1'b0});
      end
      tick();
    end
    n_checks++;
    if (done8 !== 1'b1) begin
      n_fail++;
      $display("FAIL rmid_new_done got=%b exp=1", done8);
    end
    tick();
  endtask

  task automatic test_width5();
    bit exp_seq[5] = '{1, 1, 0, 0, 1};
    data5 = 5'b10011; s_ready5 = 1'b1; start5 = 1'b1;
    tick();
    start5 = 1'b0;
    for (int k = 0; k < 5; k++) begin
      n_checks++;
      if ({s_valid5, s_out5, done5} !== {1'b1, exp_seq[k], 1'b0}) begin
        n_fail++;
        $display("FAIL w5_bit%0d got v/o/d=%b exp=%b", k,
                 {s_valid5, s_out5, done5}, {1'b1, exp_seq[k], 1'b0});
      end
      tick();
    end
    n_checks++;
    if ({done5, s_valid5, ready5} !== 3'b100) begin
      n_fail++;
      $display("FAIL w5_done6 got d/v/r=%b exp=100", {done5, s_valid5, ready5});
    end
    tick();
    n_checks++;
    if ({ready5, done5} !== 2'b10) begin
      n_fail++;
      $display("FAIL w5_ready7 got r/d=%b exp=10", {ready5, done5});
    end
  endtask

  initial begin
    rst = 1'b1;
    start8 = 1'b0; data8 = '0; s_ready8 = 1'b1;
    start5 = 1'b0; data5 = '0; s_ready5 = 1'b1;
    test_reset();
    test_basic();
    test_backpressure();
    test_start_while_busy();
    test_reset_mid_transfer();
    test_width5();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
